// File: rtl/ber_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ber_sweep_ctrl : BER-vs-SNR sweep sequencer (reset/settle/measure/emit).  |
// | Optional macro BER_SWEEP_TIMEOUT_EN: result timeout with sticky overflow. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ber_sweep_ctrl #(
  parameter logic [7:0] SIGMA              = 8'h1C,
  parameter int         NBT_COUNT_BITS_ERR = 64,
  parameter int         NBT_WIN            = 32,
  parameter int         RST_CYCLES         = 16
`ifdef BER_SWEEP_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES     = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [7:0]                    i_sigma_start,
  input  logic [7:0]                    i_sigma_step,
  input  logic [7:0]                    i_num_points,
  input  logic [NBT_WIN-1:0]            i_settle_cycles,
  input  logic [NBT_WIN-1:0]            i_meas_cycles,
  input  logic [NBT_COUNT_BITS_ERR-1:0] i_accum_err_I,
  input  logic [NBT_COUNT_BITS_ERR-1:0] i_accum_bit_I,
  input  logic                          i_res_ready,
  output logic                          o_rst_soft,
  output logic                          o_en_rx_soft,
  output logic [7:0]                    o_sigma,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_res_valid,
  output logic [7:0]                    o_res_idx,
  output logic [7:0]                    o_res_sigma,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_res_err,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_res_bits,
  output logic                          o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_MEAS   = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                          state_q;
  logic [NBT_WIN-1:0]              cnt_q, settle_q, meas_q;
  logic [7:0]                      num_q, step_q, idx_q, sigma_q;
  logic [NBT_COUNT_BITS_ERR-1:0]   err0_q, bit0_q, res_err_q, res_bits_q;
  logic [7:0]                      res_idx_q, res_sigma_q;
  logic                            rst_soft_q, en_rx_q, busy_q, done_q, res_valid_q;

  logic signed [8:0] sigma_sum_d;
  logic [7:0]        sigma_next_d;
  logic              rst_last_d, settle_last_d, meas_last_d, last_point_d;
  logic              emit_drop_d, emit_adv_d;

  assign sigma_sum_d = $signed({sigma_q[7], sigma_q}) + $signed({step_q[7], step_q});

  // Clamp to the signed 8-bit range when the 9-bit sum leaves it.
  always_comb begin
    sigma_next_d = sigma_sum_d[7:0];
    if (sigma_sum_d[8] != sigma_sum_d[7])
      sigma_next_d = sigma_sum_d[8] ? 8'h80 : 8'h7F;
  end

  assign rst_last_d    = (cnt_q == NBT_WIN'(RST_CYCLES - 1));
  assign settle_last_d = (settle_q == '0) || (cnt_q == settle_q - NBT_WIN'(1));
  assign meas_last_d   = (meas_q == '0) || (cnt_q == meas_q - NBT_WIN'(1));
  assign last_point_d  = (idx_q == num_q - 8'd1);

`ifdef BER_SWEEP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             overflow_q;
  assign emit_drop_d = !i_res_ready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign o_overflow  = overflow_q;
`else
  assign emit_drop_d = 1'b0;
  assign o_overflow  = 1'b0;
`endif
  assign emit_adv_d = res_valid_q && (i_res_ready || emit_drop_d);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      meas_q      <= '0;
      num_q       <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      sigma_q     <= SIGMA;
      err0_q      <= '0;
      bit0_q      <= '0;
      res_err_q   <= '0;
      res_bits_q  <= '0;
      res_idx_q   <= '0;
      res_sigma_q <= '0;
      rst_soft_q  <= 1'b1;
      en_rx_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef BER_SWEEP_TIMEOUT_EN
      tmo_q       <= '0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q     <= 1'b0;
          rst_soft_q <= 1'b1;
          en_rx_q    <= 1'b0;
          if (i_start && !i_abort) begin
            num_q    <= i_num_points;
            step_q   <= i_sigma_step;
            settle_q <= i_settle_cycles;
            meas_q   <= i_meas_cycles;
`ifdef BER_SWEEP_TIMEOUT_EN
            overflow_q <= 1'b0;
`endif
            if (i_num_points == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              sigma_q <= i_sigma_start;
              idx_q   <= 8'd0;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_RST;
            end
          end
        end
        S_RST: begin
          if (rst_last_d) begin
            rst_soft_q <= 1'b0;
            en_rx_q    <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + NBT_WIN'(1);
          end
        end
        S_SETTLE: begin
          if (settle_last_d) begin
            err0_q  <= i_accum_err_I;
            bit0_q  <= i_accum_bit_I;
            cnt_q   <= '0;
            state_q <= S_MEAS;
          end else begin
            cnt_q <= cnt_q + NBT_WIN'(1);
          end
        end
        S_MEAS: begin
          if (meas_last_d) begin
            // Modular subtraction keeps the window count correct across accumulator wrap.
            res_err_q   <= (meas_q == '0) ? '0 : i_accum_err_I - err0_q;
            res_bits_q  <= (meas_q == '0) ? '0 : i_accum_bit_I - bit0_q;
            res_idx_q   <= idx_q;
            res_sigma_q <= sigma_q;
            res_valid_q <= 1'b1;
            en_rx_q     <= 1'b0;
            state_q     <= S_EMIT;
`ifdef BER_SWEEP_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + NBT_WIN'(1);
          end
        end
        S_EMIT: begin
`ifdef BER_SWEEP_TIMEOUT_EN
          tmo_q <= emit_adv_d ? '0 : tmo_q + TMO_W'(1);
          if (emit_drop_d) overflow_q <= 1'b1;
`endif
          if (emit_adv_d) begin
            res_valid_q <= 1'b0;
            if (last_point_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              idx_q      <= idx_q + 8'd1;
              sigma_q    <= sigma_next_d;
              cnt_q      <= '0;
              rst_soft_q <= 1'b1;
              state_q    <= S_RST;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (i_abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        res_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        rst_soft_q  <= 1'b1;
        en_rx_q     <= 1'b0;
      end
    end
  end

  assign o_rst_soft   = rst_soft_q;
  assign o_en_rx_soft = en_rx_q;
  assign o_sigma      = sigma_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_res_valid  = res_valid_q;
  assign o_res_idx    = res_idx_q;
  assign o_res_sigma  = res_sigma_q;
  assign o_res_err    = res_err_q;
  assign o_res_bits   = res_bits_q;

endmodule
`default_nettype wire

// File: tb/tb_ber_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ber_sweep_ctrl : self-checking bench for ber_sweep_ctrl.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ber_sweep_ctrl;
  logic        clk = 1'b0;
  logic        i_reset, i_start, i_abort, i_res_ready;
  logic [7:0]  i_sigma_start, i_sigma_step, i_num_points;
  logic [31:0] i_settle_cycles, i_meas_cycles;
  logic [63:0] i_accum_err_I, i_accum_bit_I;
  logic        o_rst_soft, o_en_rx_soft, o_busy, o_done, o_res_valid, o_overflow;
  logic [7:0]  o_sigma, o_res_idx, o_res_sigma;
  logic [63:0] o_res_err, o_res_bits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ber_sweep_ctrl dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_sigma_start(i_sigma_start), .i_sigma_step(i_sigma_step), .i_num_points(i_num_points),
    .i_settle_cycles(i_settle_cycles), .i_meas_cycles(i_meas_cycles),
    .i_accum_err_I(i_accum_err_I), .i_accum_bit_I(i_accum_bit_I), .i_res_ready(i_res_ready),
    .o_rst_soft(o_rst_soft), .o_en_rx_soft(o_en_rx_soft), .o_sigma(o_sigma), .o_busy(o_busy),
    .o_done(o_done), .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res_sigma(o_res_sigma),
    .o_res_err(o_res_err), .o_res_bits(o_res_bits), .o_overflow(o_overflow)
  );

  // Datapath accumulator model: err grows by err_rate every err_period cycles, bits by bit_rate.
  logic [63:0] err_rate = 64'd1, bit_rate = 64'd1, load_err = 0, load_bit = 0;
  int          err_period = 1;
  int          load_gen = 0;
  initial begin
    int seen, phase;
    seen = 0; phase = 0;
    i_accum_err_I = 0; i_accum_bit_I = 0;
    forever begin
      @(posedge clk); #1;
      if (load_gen != seen) begin
        seen = load_gen; phase = 0;
        i_accum_err_I = load_err; i_accum_bit_I = load_bit;
      end else begin
        phase++;
        if (phase >= err_period) begin phase = 0; i_accum_err_I = i_accum_err_I + err_rate; end
        i_accum_bit_I = i_accum_bit_I + bit_rate;
      end
    end
  end

  logic rdy_level = 1'b1, rdy_rand = 1'b0;
  initial begin
    i_res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_level;
    end
  end

  typedef struct {logic [7:0] idx; logic [7:0] sigma; logic [63:0] err; logic [63:0] bits;} rec_t;
  rec_t recs[$];
  int   rst_runs[$], en_runs[$];
  int   done_cnt = 0, rst_run = 0, en_run = 0;
  logic en_prev = 1'b0, ovf_seen = 1'b0;
  always @(negedge clk) begin
    if (o_res_valid && i_res_ready) recs.push_back('{o_res_idx, o_res_sigma, o_res_err, o_res_bits});
    if (o_done) done_cnt++;
    if (o_overflow) ovf_seen = 1'b1;
    if (o_en_rx_soft && !en_prev) rst_runs.push_back(rst_run);
    if (!o_en_rx_soft && en_prev) en_runs.push_back(en_run);
    rst_run = o_rst_soft ? rst_run + 1 : 0;
    en_run  = o_en_rx_soft ? en_run + 1 : 0;
    en_prev = o_en_rx_soft;
  end

  function automatic logic [7:0] exp_sigma(input logic [7:0] s0, input logic [7:0] st, input int p);
    int v;
    v = int'($signed(s0)) + p * int'($signed(st));
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [63:0] exp_cnt(input logic [63:0] rate, input int m, input int period);
    if (m == 0) return 64'd0;
    return rate * 64'(m / period);
  endfunction

  task automatic start_sweep(input logic [7:0] s0, input logic [7:0] st, input logic [7:0] n,
                             input logic [31:0] set, input logic [31:0] mea);
    i_sigma_start = s0; i_sigma_step = st; i_num_points = n;
    i_settle_cycles = set; i_meas_cycles = mea;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wait_done: o_done not seen within %0d cycles", budget); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 0; i_abort = 0;
    i_sigma_start = 0; i_sigma_step = 0; i_num_points = 0; i_settle_cycles = 0; i_meas_cycles = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_rst_soft, o_en_rx_soft, o_busy, o_done, o_res_valid, o_overflow} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 100000",
        {o_rst_soft, o_en_rx_soft, o_busy, o_done, o_res_valid, o_overflow});
    end
    checks++;
    if (o_sigma !== 8'h1C) begin errors++; $display("FAIL reset_sigma: got %h want 1c", o_sigma); end
    checks++;
    if ({o_res_idx, o_res_sigma, o_res_err, o_res_bits} !== '0) begin
      errors++; $display("FAIL reset_record: idx %h sigma %h err %h bits %h want 0",
        o_res_idx, o_res_sigma, o_res_err, o_res_bits);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_basic();
    int r0, d0, rr0, er0;
    err_rate = 1; err_period = 10; bit_rate = 1; rdy_rand = 0; rdy_level = 1;
    r0 = recs.size(); d0 = done_cnt; rr0 = rst_runs.size(); er0 = en_runs.size();
    start_sweep(8'h10, 8'h04, 8'd3, 32'd20, 32'd100);
    wait_done(2000);
    repeat (5) @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
    checks++;
    if (recs.size() - r0 != 3) begin errors++; $display("FAIL basic_count: got %0d records want 3", recs.size() - r0); end
    else for (int p = 0; p < 3; p++) begin
      checks++;
      if (recs[r0+p].idx !== 8'(p) || recs[r0+p].sigma !== 8'(8'h10 + 4*p) ||
          recs[r0+p].err !== 64'd10 || recs[r0+p].bits !== 64'd100) begin
        errors++; $display("FAIL basic_rec%0d: idx %0d sigma %h err %0d bits %0d want %0d %h 10 100",
          p, recs[r0+p].idx, recs[r0+p].sigma, recs[r0+p].err, recs[r0+p].bits, p, 8'(8'h10 + 4*p));
      end
      checks++;
      if (en_runs.size() <= er0 + p || en_runs[er0+p] != 120) begin
        errors++; $display("FAIL basic_enrx%0d: got %0d cycles want 120",
          p, (en_runs.size() > er0 + p) ? en_runs[er0+p] : -1);
      end
      if (p > 0) begin
        checks++;
        if (rst_runs.size() <= rr0 + p || rst_runs[rr0+p] != 16) begin
          errors++; $display("FAIL basic_rst%0d: got %0d cycles want 16",
            p, (rst_runs.size() > rr0 + p) ? rst_runs[rr0+p] : -1);
        end
      end
    end
    checks++;
    if (o_busy !== 1'b0 || o_rst_soft !== 1'b1) begin
      errors++; $display("FAIL basic_idle: busy %b rst %b want 0 1", o_busy, o_rst_soft);
    end
  endtask

  task automatic test_backpressure();
    int r0, w;
    logic [7:0] ci, cs; logic [63:0] ce, cb;
    err_rate = 2; err_period = 1; bit_rate = 1; rdy_rand = 0; rdy_level = 0;
    r0 = recs.size();
    start_sweep(8'h00, 8'h01, 8'd2, 32'd5, 32'd30);
    w = 0;
    do begin @(negedge clk); w++; end while (!o_res_valid && w < 500);
    checks++;
    if (!o_res_valid) begin errors++; $display("FAIL bp_valid: valid %b want 1 within 500 cycles", o_res_valid); end
    ci = o_res_idx; cs = o_res_sigma; ce = o_res_err; cb = o_res_bits;
    checks++;
    if (ci !== 8'd0 || cs !== 8'h00 || ce !== 64'd60 || cb !== 64'd30) begin
      errors++; $display("FAIL bp_rec0: idx %0d sigma %h err %0d bits %0d want 0 00 60 30", ci, cs, ce, cb);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (!o_res_valid || o_res_idx !== ci || o_res_sigma !== cs || o_res_err !== ce ||
          o_res_bits !== cb || o_rst_soft !== 1'b0 || o_en_rx_soft !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: valid %b idx %0d err %0d rst %b en %b want stable record, 0 0",
          i, o_res_valid, o_res_idx, o_res_err, o_rst_soft, o_en_rx_soft);
      end
    end
    rdy_level = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_res_valid !== 1'b0 || o_rst_soft !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid %b rst %b want 0 1", o_res_valid, o_rst_soft);
    end
    @(posedge clk); #1;
    wait_done(1000);
    checks++;
    if (recs.size() - r0 != 2) begin errors++; $display("FAIL bp_count: got %0d want 2", recs.size() - r0); end
  endtask

  task automatic test_saturation();
    logic [7:0] s0v[2] = '{8'h7C, 8'h84};
    logic [7:0] stv[2] = '{8'h04, 8'hFC};
    int r0;
    err_rate = 1; err_period = 1; bit_rate = 1; rdy_rand = 0; rdy_level = 1;
    for (int c = 0; c < 2; c++) begin
      r0 = recs.size();
      start_sweep(s0v[c], stv[c], 8'd3, 32'd2, 32'd4);
      wait_done(1000);
      checks++;
      if (recs.size() - r0 != 3) begin errors++; $display("FAIL sat_count%0d: got %0d want 3", c, recs.size() - r0); end
      else for (int p = 0; p < 3; p++) begin
        checks++;
        if (recs[r0+p].sigma !== exp_sigma(s0v[c], stv[c], p)) begin
          errors++; $display("FAIL sat_sigma%0d_%0d: got %h want %h", c, p, recs[r0+p].sigma, exp_sigma(s0v[c], stv[c], p));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int r0;
    err_rate = 1; err_period = 1; bit_rate = 1; rdy_rand = 0; rdy_level = 1;
    load_err = 64'hFFFF_FFFF_FFFF_FFE0; load_bit = 64'hFFFF_FFFF_FFFF_FFF8; load_gen++;
    r0 = recs.size();
    start_sweep(8'h01, 8'h01, 8'd1, 32'd0, 32'd32);
    wait_done(500);
    checks++;
    if (recs.size() - r0 != 1 || recs[r0].err !== 64'd32 || recs[r0].bits !== 64'd32) begin
      errors++; $display("FAIL wrap: records %0d err %0d bits %0d want 1 32 32", recs.size() - r0,
        (recs.size() > r0) ? recs[r0].err : 64'd0, (recs.size() > r0) ? recs[r0].bits : 64'd0);
    end
  endtask

  task automatic test_num_zero();
    start_sweep(8'h22, 8'h01, 8'd0, 32'd3, 32'd3);
    @(negedge clk);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_pulse: done %b busy %b want 1 0", o_done, o_busy); end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_after: done %b busy %b want 0 0", o_done, o_busy); end
    @(posedge clk); #1;
    i_abort = 1'b1;
    start_sweep(8'h22, 8'h01, 8'd2, 32'd3, 32'd3);
    i_abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rst_soft !== 1'b1) begin
        errors++; $display("FAIL abort_start: busy %b done %b rst %b want 0 0 1", o_busy, o_done, o_rst_soft);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int r0, d0, w;
    err_rate = 1; err_period = 1; bit_rate = 1; rdy_rand = 0; rdy_level = 1;
    r0 = recs.size(); d0 = done_cnt;
    start_sweep(8'h20, 8'h02, 8'd3, 32'd10, 32'd50);
    w = 0;
    do begin @(negedge clk); w++; end while (recs.size() == r0 && w < 500);
    w = 0;
    do begin @(negedge clk); w++; end while (!o_en_rx_soft && w < 100);
    checks++;
    if (!o_en_rx_soft) begin errors++; $display("FAIL abort_reach: en_rx %b want 1 for point 1", o_en_rx_soft); end
    repeat (30) @(posedge clk);
    #1 i_abort = 1'b1;
    @(posedge clk); #1 i_abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_busy, o_rst_soft, o_res_valid, o_en_rx_soft, o_done} !== 5'b01000) begin
      errors++; $display("FAIL abort_state: busy/rst/valid/en/done %b want 01000",
        {o_busy, o_rst_soft, o_res_valid, o_en_rx_soft, o_done});
    end
    repeat (200) @(posedge clk); #1;
    checks++;
    if (done_cnt != d0 || recs.size() - r0 != 1) begin
      errors++; $display("FAIL abort_after: done %0d records %0d want 0 1", done_cnt - d0, recs.size() - r0);
    end
    start_sweep(8'h40, 8'h02, 8'd3, 32'd10, 32'd50);
    repeat (30) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_sigma !== 8'h1C || o_busy !== 1'b0 || o_rst_soft !== 1'b1 || o_res_sigma !== 8'h00) begin
      errors++; $display("FAIL midreset: sigma %h busy %b rst %b res_sigma %h want 1c 0 1 00",
        o_sigma, o_busy, o_rst_soft, o_res_sigma);
    end
    @(posedge clk); #1 i_reset = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] s0, st, n; int set, mea, r0, d0, rr0, er0, en_exp;
    for (int it = 0; it < 6; it++) begin
      s0 = 8'($urandom_range(0, 255)); st = 8'($urandom_range(0, 255)); n = 8'($urandom_range(1, 5));
      set = $urandom_range(0, 20); mea = $urandom_range(0, 40);
      err_rate = 64'($urandom_range(0, 3)); bit_rate = 64'($urandom_range(1, 4)); err_period = 1;
      load_err = {$urandom, $urandom}; load_bit = {$urandom, $urandom}; load_gen++;
      rdy_rand = 1;
      r0 = recs.size(); d0 = done_cnt; rr0 = rst_runs.size(); er0 = en_runs.size();
      start_sweep(s0, st, n, 32'(set), 32'(mea));
      repeat (4) @(posedge clk); #1;
      start_sweep(~s0, ~st, 8'd9, 32'd7, 32'd7);
      wait_done(5000);
      repeat (3) @(posedge clk); #1;
      checks++;
      if (recs.size() - r0 != int'(n) || done_cnt - d0 != 1) begin
        errors++; $display("FAIL rnd%0d_count: records %0d done %0d want %0d 1", it, recs.size() - r0, done_cnt - d0, n);
      end else for (int p = 0; p < int'(n); p++) begin
        checks++;
        if (recs[r0+p].idx !== 8'(p) || recs[r0+p].sigma !== exp_sigma(s0, st, p) ||
            recs[r0+p].err !== exp_cnt(err_rate, mea, 1) || recs[r0+p].bits !== exp_cnt(bit_rate, mea, 1)) begin
          errors++; $display("FAIL rnd%0d_rec%0d: idx %0d sigma %h err %0d bits %0d want %0d %h %0d %0d", it, p,
            recs[r0+p].idx, recs[r0+p].sigma, recs[r0+p].err, recs[r0+p].bits,
            p, exp_sigma(s0, st, p), exp_cnt(err_rate, mea, 1), exp_cnt(bit_rate, mea, 1));
        end
        en_exp = (set == 0 ? 1 : set) + (mea == 0 ? 1 : mea);
        checks++;
        if (en_runs.size() <= er0 + p || en_runs[er0+p] != en_exp ||
            (p > 0 && (rst_runs.size() <= rr0 + p || rst_runs[rr0+p] != 16))) begin
          errors++; $display("FAIL rnd%0d_timing%0d: en %0d rst %0d want %0d 16", it, p,
            (en_runs.size() > er0 + p) ? en_runs[er0+p] : -1, (rst_runs.size() > rr0 + p) ? rst_runs[rr0+p] : -1, en_exp);
        end
      end
    end
    rdy_rand = 0; rdy_level = 1;
  endtask

  task automatic test_overflow();
`ifdef BER_SWEEP_TIMEOUT_EN
    int w, vcyc;
    rdy_rand = 0; rdy_level = 0;
    start_sweep(8'h05, 8'h01, 8'd1, 32'd0, 32'd1);
    w = 0;
    do begin @(negedge clk); w++; end while (!o_res_valid && w < 200);
    vcyc = 0;
    while (o_res_valid && vcyc < 3000) begin vcyc++; @(negedge clk); end
    checks++;
    if (vcyc != 1024 || o_overflow !== 1'b1) begin
      errors++; $display("FAIL tmo_drop: valid cycles %0d overflow %b want 1024 1", vcyc, o_overflow);
    end
    @(posedge clk); #1;
    wait_done(100);
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL tmo_sticky: overflow %b want 1", o_overflow); end
    rdy_level = 1;
    start_sweep(8'h05, 8'h01, 8'd1, 32'd0, 32'd1);
    @(negedge clk);
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL tmo_clear: overflow %b want 0", o_overflow); end
    @(posedge clk); #1;
    wait_done(500);
`else
    checks++;
    if (ovf_seen !== 1'b0 || o_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_tied: overflow seen %b want 0", ovf_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_wrap();
    test_num_zero();
    test_abort();
    test_random();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ber_sweep_ctrl.md
Name: ber_sweep_ctrl

Overview:
Sequencer that automates a BER-vs-SNR sweep over the comm datapath. It steps sigma across a programmed range and, for each point: applies a soft reset, enables RX, waits a settle window, then measures I-branch error and bit counts over a measurement window. Each point yields one result record through a valid/ready port to the register file / GPIO readout path. It takes over the soft-reset, RX-enable and sigma controls that are otherwise set manually by micro commands.

Parameters:
SIGMA, 8'sh1C, sigma driven at reset and while idle
NBT_COUNT_BITS_ERR, 64, accumulator and result width
NBT_WIN, 32, width of settle/measure cycle counts
RST_CYCLES, 16, cycles o_rst_soft is held per point
TIMEOUT_CYCLES, 1024, result-handshake timeout (optional feature only)

Ports:
clk  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_start  in  1  start sweep; accepted only in IDLE
i_abort  in  1  abort sweep; return to IDLE
i_sigma_start  in  8  signed first sigma
i_sigma_step  in  8  signed per-point increment
i_num_points  in  8  number of points
i_settle_cycles  in  NBT_WIN  settle window length
i_meas_cycles  in  NBT_WIN  measure window length
i_accum_err_I  in  NBT_COUNT_BITS_ERR  running error count from datapath
i_accum_bit_I  in  NBT_COUNT_BITS_ERR  running bit count from datapath
i_res_ready  in  1  consumer ready
o_rst_soft  out  1  datapath soft reset
o_en_rx_soft  out  1  datapath RX enable
o_sigma  out  8  signed sigma to channel
o_busy  out  1  sweep in progress
o_done  out  1  one-cycle pulse at sweep end
o_res_valid  out  1  result record valid
o_res_idx  out  8  point index, 0-based
o_res_sigma  out  8  sigma used for the point
o_res_err  out  NBT_COUNT_BITS_ERR  errors in measure window
o_res_bits  out  NBT_COUNT_BITS_ERR  bits in measure window
o_overflow  out  1  sticky: result dropped (optional feature only; else tied 0)

Behaviour:
- Reset: state IDLE; o_rst_soft=1, o_en_rx_soft=0, o_sigma=SIGMA, o_busy=0, o_done=0, o_res_valid=0, o_res_idx/err/bits/sigma=0, o_overflow=0.
- All outputs are registered.
- IDLE: o_rst_soft=1, o_en_rx_soft=0, o_sigma holds last value.
- i_start in IDLE latches all configuration inputs. Configuration changes while busy have no effect.
- i_start with i_num_points==0: o_done pulses the next cycle; o_busy stays 0.
- i_start with i_num_points>0: o_sigma=i_sigma_start, idx=0, o_busy=1; next state RST.
- RST: o_rst_soft=1, o_en_rx_soft=0 for exactly RST_CYCLES cycles -> SETTLE.
- SETTLE: o_rst_soft=0, o_en_rx_soft=1 for settle_cycles cycles (0 allowed: one-cycle pass).
  - On exit, snapshot err0/bit0 from the accumulators -> MEAS.
- MEAS: runs meas_cycles cycles (0 -> result 0).
  - On exit, o_res_err = i_accum_err_I - err0 and o_res_bits = i_accum_bit_I - bit0, modulo 2^NBT_COUNT_BITS_ERR (wrap-safe).
  - o_res_sigma/o_res_idx are loaded and o_res_valid=1 -> EMIT.
- EMIT: o_en_rx_soft=0. Record stays stable while valid && !ready; handshake completes when valid && ready.
  - After the handshake, valid drops the next cycle.
  - If idx==num_points-1 -> DONE; else idx+1, sigma+=step -> RST.
- Sigma addition saturates to [-128, +127]; idx never wraps (max 255 points).
- DONE: one-cycle o_done=1, o_busy=0 -> IDLE.
- i_abort (any non-IDLE state): IDLE next cycle, o_res_valid=0, o_busy=0, no o_done, o_rst_soft=1.
- i_abort and i_start in the same cycle in IDLE: abort wins; start is ignored.
- i_start while busy: ignored.
- i_reset mid-sweep: full reset values next cycle.

Optional Feature:
Macro BER_SWEEP_TIMEOUT_EN.
- Defined: EMIT counts cycles with valid && !ready. On reaching TIMEOUT_CYCLES the record is dropped, o_overflow is set (sticky, cleared only by i_reset or an accepted i_start), and the sweep advances as if accepted.
- Undefined: EMIT waits indefinitely; o_overflow is constant 0.

Test Plan:
- Start with sigma_start=0x10, step=0x04, num=3, settle=20, meas=100, ready=1; accumulators increment err by 1 every 10 cycles and bits by 1 per cycle -> 3 records, idx 0/1/2, sigma 0x10/0x14/0x18, bits=100, err=10 each; o_done pulses once; o_rst_soft high for 16 cycles before each point.
- Backpressure: hold ready=0 for 50 cycles in EMIT -> record fields stable throughout; next point starts only after the handshake.
- Saturation: sigma_start=0x7C, step=0x04, num=3 -> o_res_sigma = 0x7C, 0x7F, 0x7F.
- Wrap: err0=0xFFFF_FFFF_FFFF_FFF0, 32 errors during meas -> o_res_err=32.
- Abort in MEAS of point 1 -> o_busy=0 next cycle, no o_done, o_rst_soft=1, o_res_valid=0. Also: num=0 start -> o_done pulse, no busy.
- BER_SWEEP_TIMEOUT_EN defined, ready=0 for 2000 cycles -> o_overflow=1 at 1024 cycles of valid; sweep completes; a new start clears o_overflow.
